// File: rtl/ram_reader_pkg.sv
// Shared types and constants for the RAM range reader.
package ram_reader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } rd_state_t;

    localparam int BUF_DEPTH = 2;
    localparam int BUF_CNT_W = 2;

endpackage

// File: rtl/ram_reader_skid_buf.sv
// Two-entry data+last FIFO sitting between the registered RAM output and the stream port.
module ram_reader_skid_buf
    import ram_reader_pkg::*;
#(
    parameter int WORD_SIZE = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 push,
    input  logic                 push_last,
    input  logic [WORD_SIZE-1:0] push_word,
    input  logic                 pop,
    input  logic                 flush,
    output logic [BUF_CNT_W-1:0] count,
    output logic                 out_valid,
    output logic                 in_ready,
    output logic [WORD_SIZE-1:0] out_word,
    output logic                 out_last
);

    logic [WORD_SIZE:0]   entry_reg [BUF_DEPTH];
    logic                 rd_ptr_reg;
    logic                 wr_ptr_reg;
    logic [BUF_CNT_W-1:0] count_reg;
    logic [BUF_CNT_W-1:0] count_next;
    logic                 do_push;
    logic                 do_pop;
    logic                 full;

    assign full      = (count_reg == BUF_CNT_W'(BUF_DEPTH));
    assign do_pop    = pop && (count_reg != '0) && !flush;
    // A push into a full buffer is only legal when the head leaves in the same cycle.
    assign do_push   = push && !flush && (!full || do_pop);

    always_comb begin
        count_next = count_reg;
        if (do_push && !do_pop) begin
            count_next = count_reg + 1'b1;
        end else if (do_pop && !do_push) begin
            count_next = count_reg - 1'b1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < BUF_DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    entry_reg[gi] <= '0;
                end else if (do_push && (wr_ptr_reg == 1'(gi))) begin
                    entry_reg[gi] <= {push_last, push_word};
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_reg <= 1'b0;
            wr_ptr_reg <= 1'b0;
            count_reg  <= '0;
        end else if (flush) begin
            rd_ptr_reg <= 1'b0;
            wr_ptr_reg <= 1'b0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= ~wr_ptr_reg;
            end
            if (do_pop) begin
                rd_ptr_reg <= ~rd_ptr_reg;
            end
            count_reg <= count_next;
        end
    end

    assign count     = count_reg;
    assign out_valid = (count_reg != '0);
    assign in_ready  = !full;
    assign out_word  = entry_reg[rd_ptr_reg][WORD_SIZE-1:0];
    assign out_last  = out_valid && entry_reg[rd_ptr_reg][WORD_SIZE];

endmodule

// File: rtl/ram_range_reader.sv
// Burst read sequencer over a wrapping RAM address range, streamed out as valid/ready.
// Define RAM_RANGE_READER_ABORT_EN to add the abort input that cancels a running burst.
module ram_range_reader
    import ram_reader_pkg::*;
#(
    parameter int WORD_SIZE = 16,
    parameter int ADDR_SIZE = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [ADDR_SIZE-1:0] start_addr,
    input  logic [ADDR_SIZE:0]   num_words,
`ifdef RAM_RANGE_READER_ABORT_EN
    input  logic                 abort,
`endif
    output logic                 busy,
    output logic                 done,
    output logic                 ram_rd_en,
    output logic [ADDR_SIZE-1:0] ram_rd_addr,
    input  logic [WORD_SIZE-1:0] ram_rd_word,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WORD_SIZE-1:0] out_word,
    output logic                 out_last
);

    rd_state_t              state_reg;
    rd_state_t              state_next;
    logic [ADDR_SIZE-1:0]   addr_reg;
    logic [ADDR_SIZE:0]     remaining_reg;
    logic                   inflight_reg;
    logic                   inflight_last_reg;
    logic                   done_reg;
    logic                   done_next;

    logic                   accept_burst;
    logic                   accept_empty;
    logic                   issue;
    logic                   issue_last;
    logic                   pop;
    logic                   push;
    logic                   abort_hit;
    logic                   drain_empty;
    logic [2:0]             occupancy;
    logic [BUF_CNT_W-1:0]   buf_count;
    logic                   buf_in_ready;

`ifdef RAM_RANGE_READER_ABORT_EN
    assign abort_hit = abort && (state_reg != IDLE);
`else
    assign abort_hit = 1'b0;
`endif

    assign accept_burst = (state_reg == IDLE) && start && (num_words != '0);
    assign accept_empty = (state_reg == IDLE) && start && (num_words == '0);
    assign pop          = out_valid && out_ready;
    // Words that will be held or still returning after this edge, before any new issue.
    assign occupancy    = 3'(buf_count) + 3'(inflight_reg) - 3'(pop);
    assign issue        = (state_reg == ISSUE) && !abort_hit && (occupancy < 3'(BUF_DEPTH));
    assign issue_last   = issue && (remaining_reg == (ADDR_SIZE+1)'(1));
    assign push         = inflight_reg && !abort_hit;
    assign drain_empty  = !inflight_reg && (occupancy == 3'd0);

    always_comb begin
        state_next = state_reg;
        done_next  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (accept_burst) begin
                    state_next = ISSUE;
                end
                done_next = accept_empty;
            end
            ISSUE: begin
                if (abort_hit) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end else if (issue_last) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (abort_hit || drain_empty) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg         <= IDLE;
            addr_reg          <= '0;
            remaining_reg     <= '0;
            inflight_reg      <= 1'b0;
            inflight_last_reg <= 1'b0;
            done_reg          <= 1'b0;
        end else begin
            state_reg         <= state_next;
            done_reg          <= done_next;
            inflight_reg      <= issue;
            inflight_last_reg <= issue_last;
            if (accept_burst) begin
                addr_reg      <= start_addr;
                remaining_reg <= num_words;
            end else if (issue) begin
                addr_reg      <= addr_reg + 1'b1;
                remaining_reg <= remaining_reg - 1'b1;
            end
        end
    end

    ram_reader_skid_buf #(
        .WORD_SIZE (WORD_SIZE)
    ) u_skid_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_last (inflight_last_reg),
        .push_word (ram_rd_word),
        .pop       (pop),
        .flush     (abort_hit),
        .count     (buf_count),
        .out_valid (out_valid),
        .in_ready  (buf_in_ready),
        .out_word  (out_word),
        .out_last  (out_last)
    );

    assign busy        = (state_reg != IDLE);
    assign done        = done_reg;
    assign ram_rd_en   = issue;
    assign ram_rd_addr = addr_reg;

    // Issue throttling already guarantees room; in_ready is kept for integrators only.
    logic unused_ok;
    assign unused_ok = buf_in_ready;

endmodule

// File: doc/ram_range_reader.md
Name: ram_range_reader

Overview:
Read-side sequencer for the dispatcher's 2-port RAM. On a start command it issues a burst of reads over a contiguous, wrapping address range. It absorbs the RAM's 1-cycle registered read latency and presents the words as a valid/ready stream with full throughput under backpressure. The RAM's write port is driven by other dispatcher logic.

Parameters:
WORD_SIZE, 16, width of one RAM word.
ADDR_SIZE, 5, RAM address width; RAM depth is 2**ADDR_SIZE.

Ports:
clk  in  1  clock.
rst_n  in  1  asynchronous active-low reset.
start  in  1  one-cycle burst request; sampled only in IDLE.
start_addr  in  ADDR_SIZE  first address of the burst.
num_words  in  ADDR_SIZE+1  burst length, 0 to 2**ADDR_SIZE.
busy  out  1  high from the cycle after an accepted start until the cycle done is asserted.
done  out  1  one-cycle pulse after the last word is handed off.
ram_rd_en  out  1  RAM read enable.
ram_rd_addr  out  ADDR_SIZE  RAM read address.
ram_rd_word  in  WORD_SIZE  RAM data; valid the cycle after ram_rd_en.
out_valid  out  1  stream word valid.
out_ready  in  1  consumer ready.
out_word  out  WORD_SIZE  stream data.
out_last  out  1  marks the final word of the burst; qualified by out_valid.

Behaviour:
- Reset (async, rst_n=0): FSM to IDLE; busy, done, ram_rd_en, out_valid, out_last = 0; ram_rd_addr, out_word = 0; buffer emptied; counters cleared.
- FSM states: IDLE, ISSUE, DRAIN.
- IDLE:
  - start with num_words>0: latch address and count, go to ISSUE.
  - start with num_words==0: done pulses the next cycle, no reads, stay in IDLE.
- ISSUE:
  - ram_rd_en=1 in a cycle only if (words buffered + reads in flight) < 2 after counting any pop in that same cycle.
  - Each issue increments the address modulo 2**ADDR_SIZE (address 31 wraps to 0) and decrements the remaining count.
  - When the last read is issued, go to DRAIN.
- DRAIN: wait until the buffer is empty and no read is in flight, then pulse done for 1 cycle, drop busy, and go to IDLE.
- Data capture: ram_rd_word is written into the 2-entry buffer exactly one cycle after each issued read. The RAM output is never sampled in any other cycle.
- Stream rules:
  - A transfer occurs when out_valid && out_ready.
  - out_word and out_last stay stable while out_valid && !out_ready.
  - A push and a pop may occur in the same cycle.
- Latency: start to first out_valid is 3 cycles (latch, issue, capture). With out_ready held high, one word per cycle follows, so an N-word burst completes in N+3 cycles, then done.
- out_last is asserted on the word whose ordinal equals num_words.
- start while busy is ignored; no queueing.
- Reset mid-burst: all state is dropped immediately; no done pulse is generated.

Optional Feature:
RAM_RANGE_READER_ABORT_EN
- Defined: adds input abort (1 bit).
  - abort in ISSUE or DRAIN stops issuing reads the same cycle and flushes the buffer. Any in-flight read word is discarded on its return.
  - out_valid=0 from the next cycle. done pulses once both the in-flight read and the buffer are cleared; out_last is never emitted for that burst.
  - abort in IDLE has no effect.
- Undefined: no abort port; every burst runs to completion.

Decomposition:
- Package ram_reader_pkg: FSM state enum (IDLE/ISSUE/DRAIN) and the buffer depth constant (2).
- Sub-module ram_reader_skid_buf: 2-entry data+last FIFO with push, pop, flush, count, and valid/ready outputs. The top level keeps the FSM, address/count logic, and in-flight bit.

Test Plan:
- start_addr=4, num_words=3, RAM[4..6]=A,B,C, out_ready=1 → A,B,C on consecutive cycles starting 3 cycles after start; out_last on C; done 1 cycle after C.
- start_addr=30, num_words=4 → reads addresses 30,31,0,1 in that order; output order matches.
- num_words=8, out_ready toggling 1,0,0,1,... → no word lost or duplicated; out_word is stable while stalled; at most 2 words are ever buffered.
- num_words=0 → done pulses 1 cycle after start; ram_rd_en never asserted; out_valid stays 0.
- Second start while busy → ignored; exactly the first burst's words are emitted; rst_n asserted mid-burst → all outputs 0 immediately and no done pulse.
- (ABORT_EN) abort 2 cycles after the first out_valid of a 16-word burst → ram_rd_en=0 the same cycle; out_valid=0 the next cycle; a single done pulse; out_last never asserted.
